median_final_actor: RTL and testbench

Terminal stage of the median-filter actor chain, directly downstream of the middle partition actors. Per window it takes one pixel stream plus pivot, buffer size, median position and second-median tokens. It classifies each pixel against the pivot and resolves the median in one final decision step. It emits one result token (median value plus an exact flag) per window.

---
 rtl/median_final_actor.sv | 194 +++++++++++++++++++
 tb/tb_median_final_actor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/median_final_actor.sv
// Last stage of the median-filter actor chain: one pixel window in, one median/exact token out.
// Optional MEDIAN_FINAL_AVG_EN averages the selected value with the second-median token.
module median_final_actor #(
    parameter MEDIAN_POS    = 5'd8,
    parameter BUFF_SIZE     = 5'd16,
    parameter BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
    parameter DEFAULT_PIVOT = 8'd127
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               in_px,
    output logic                     in_px_rd,
    input  logic                     in_px_empty,
    input  logic [7:0]               in_pivot,
    output logic                     in_pivot_rd,
    input  logic                     in_pivot_empty,
    input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
    output logic                     in_buff_size_rd,
    input  logic                     in_buff_size_empty,
    input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
    output logic                     in_median_pos_rd,
    input  logic                     in_median_pos_empty,
    input  logic [7:0]               in_second_median_value,
    output logic                     in_second_median_value_rd,
    input  logic                     in_second_median_value_empty,
    output logic [7:0]               out_median,
    output logic                     out_median_wr,
    input  logic                     out_median_full,
    output logic                     out_exact
);
    localparam int SB = BUFF_SIZE_BIT;
    localparam int CW = BUFF_SIZE_BIT + 1;

    typedef enum logic [1:0] {S_SAMPLE, S_FILL, S_DECIDE, S_EMIT} state_t;
    state_t r_state, w_state_next;

    logic [7:0]    r_pivot, r_max_lt, r_min_gt, r_out_median;
    logic [SB-1:0] r_buff_size, r_median_pos, r_cnt_lt, r_cnt_eq, r_pix_cnt;
    logic          r_pivot_ok, r_size_ok, r_pos_ok, r_second_ok, r_out_exact;

    logic w_pivot_take, w_size_take, w_pos_take, w_second_take, w_px_take;
    logic w_all_ok, w_last_px;
    logic [SB-1:0] w_size_val;

    assign w_pivot_take  = in_pivot_rd & ~in_pivot_empty;
    assign w_size_take   = in_buff_size_rd & ~in_buff_size_empty;
    assign w_pos_take    = in_median_pos_rd & ~in_median_pos_empty;
    assign w_second_take = in_second_median_value_rd & ~in_second_median_value_empty;
    assign w_px_take     = in_px_rd & ~in_px_empty;
    // A token taken this cycle counts as present, so SAMPLE leaves on the same edge.
    assign w_all_ok   = (r_pivot_ok | w_pivot_take) & (r_size_ok | w_size_take) &
                        (r_pos_ok | w_pos_take) & (r_second_ok | w_second_take);
    assign w_size_val = w_size_take ? in_buff_size : r_buff_size;
    assign w_last_px  = w_px_take & (r_pix_cnt == r_buff_size - SB'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_SAMPLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next              = r_state;
        in_px_rd                  = 1'b0;
        in_pivot_rd               = 1'b0;
        in_buff_size_rd           = 1'b0;
        in_median_pos_rd          = 1'b0;
        in_second_median_value_rd = 1'b0;
        out_median_wr             = 1'b0;
        case (r_state)
            S_SAMPLE: begin
                in_pivot_rd               = reset & ~r_pivot_ok;
                in_buff_size_rd           = reset & ~r_size_ok;
                in_median_pos_rd          = reset & ~r_pos_ok;
                in_second_median_value_rd = reset & ~r_second_ok;
                if (w_all_ok) w_state_next = (w_size_val == '0) ? S_DECIDE : S_FILL;
            end
            S_FILL: begin
                in_px_rd = reset;
                if (w_last_px) w_state_next = S_DECIDE;
            end
            S_DECIDE: w_state_next = S_EMIT;
            S_EMIT: begin
                out_median_wr = reset & ~out_median_full;
                if (!out_median_full) w_state_next = S_SAMPLE;
            end
            default: w_state_next = S_SAMPLE;
        endcase
    end

    // One extra bit keeps L-1 and L+E clear of the median position range.
    logic [CW-1:0] w_m, w_l, w_e, w_n, w_le, w_l_m1;
    logic [7:0]    w_sel, w_result;
    logic          w_exact;

    assign w_m    = {1'b0, r_median_pos};
    assign w_l    = {1'b0, r_cnt_lt};
    assign w_e    = {1'b0, r_cnt_eq};
    assign w_n    = {1'b0, r_buff_size};
    assign w_le   = w_l + w_e;
    assign w_l_m1 = w_l - CW'(1);

    always_comb begin
        w_sel   = r_min_gt;
        w_exact = 1'b0;
        if (w_n == '0 || w_m >= w_n) begin
            w_sel = r_pivot;
        end else if (w_m >= w_l && w_m < w_le) begin
            w_sel   = r_pivot;
            w_exact = 1'b1;
        end else if (w_m == w_l_m1) begin
            w_sel   = r_max_lt;
            w_exact = 1'b1;
        end else if (w_m == w_le) begin
            w_exact = 1'b1;
        end else if (w_m < w_l) begin
            w_sel = r_max_lt;
        end
    end

`ifdef MEDIAN_FINAL_AVG_EN
    logic [7:0] r_second;
    logic [8:0] w_sum;
    assign w_sum    = {1'b0, w_sel} + {1'b0, r_second};
    assign w_result = w_sum[8:1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                               r_second <= DEFAULT_PIVOT;
        else if (r_state == S_SAMPLE && w_second_take) r_second <= in_second_median_value;
    end
`else
    // The second-median token is consumed for handshake symmetry only.
    logic w_unused_second;
    assign w_unused_second = ^in_second_median_value;
    assign w_result        = w_sel;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pivot      <= DEFAULT_PIVOT;
            r_buff_size  <= SB'(BUFF_SIZE);
            r_median_pos <= SB'(MEDIAN_POS);
            r_pivot_ok   <= 1'b0;
            r_size_ok    <= 1'b0;
            r_pos_ok     <= 1'b0;
            r_second_ok  <= 1'b0;
            r_cnt_lt     <= '0;
            r_cnt_eq     <= '0;
            r_pix_cnt    <= '0;
            r_max_lt     <= 8'd0;
            r_min_gt     <= 8'd255;
            r_out_median <= 8'd0;
            r_out_exact  <= 1'b0;
        end else begin
            case (r_state)
                S_SAMPLE: begin
                    if (w_pivot_take)  begin r_pivot <= in_pivot;          r_pivot_ok  <= 1'b1; end
                    if (w_size_take)   begin r_buff_size <= in_buff_size;  r_size_ok   <= 1'b1; end
                    if (w_pos_take)    begin r_median_pos <= in_median_pos; r_pos_ok   <= 1'b1; end
                    if (w_second_take) r_second_ok <= 1'b1;
                    if (w_all_ok) begin
                        r_pivot_ok  <= 1'b0;
                        r_size_ok   <= 1'b0;
                        r_pos_ok    <= 1'b0;
                        r_second_ok <= 1'b0;
                        r_cnt_lt    <= '0;
                        r_cnt_eq    <= '0;
                        r_pix_cnt   <= '0;
                        r_max_lt    <= 8'd0;
                        r_min_gt    <= 8'd255;
                    end
                end
                S_FILL: if (w_px_take) begin
                    if (in_px < r_pivot) begin
                        r_cnt_lt <= r_cnt_lt + SB'(1);
                        if (in_px > r_max_lt) r_max_lt <= in_px;
                    end else if (in_px == r_pivot) begin
                        r_cnt_eq <= r_cnt_eq + SB'(1);
                    end else if (in_px < r_min_gt) begin
                        r_min_gt <= in_px;
                    end
                    r_pix_cnt <= r_pix_cnt + SB'(1);
                end
                S_DECIDE: begin
                    r_out_median <= w_result;
                    r_out_exact  <= w_exact;
                end
                default: ;
            endcase
        end
    end

    assign out_median = r_out_median;
    assign out_exact  = r_out_exact;
endmodule

// File: tb/tb_median_final_actor.sv
// Scoreboard bench for median_final_actor: FIFO models on every input, expected tokens queued per window.
module tb_median_final_actor;
    localparam int SB = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    in_px = '0, in_pivot = '0, in_second_median_value = '0;
    logic [SB-1:0] in_buff_size = '0, in_median_pos = '0;
    logic          in_px_empty = 1'b1, in_pivot_empty = 1'b1, in_buff_size_empty = 1'b1;
    logic          in_median_pos_empty = 1'b1, in_second_median_value_empty = 1'b1;
    logic          out_median_full = 1'b0;
    logic          in_px_rd, in_pivot_rd, in_buff_size_rd, in_median_pos_rd, in_second_median_value_rd;
    logic [7:0]    out_median;
    logic          out_median_wr, out_exact;

    always #5 clock = ~clock;

    median_final_actor dut (
        .clock(clock), .reset(reset),
        .in_px(in_px), .in_px_rd(in_px_rd), .in_px_empty(in_px_empty),
        .in_pivot(in_pivot), .in_pivot_rd(in_pivot_rd), .in_pivot_empty(in_pivot_empty),
        .in_buff_size(in_buff_size), .in_buff_size_rd(in_buff_size_rd),
        .in_buff_size_empty(in_buff_size_empty),
        .in_median_pos(in_median_pos), .in_median_pos_rd(in_median_pos_rd),
        .in_median_pos_empty(in_median_pos_empty),
        .in_second_median_value(in_second_median_value),
        .in_second_median_value_rd(in_second_median_value_rd),
        .in_second_median_value_empty(in_second_median_value_empty),
        .out_median(out_median), .out_median_wr(out_median_wr),
        .out_median_full(out_median_full), .out_exact(out_exact)
    );

    logic [7:0]    q_px[$], q_pivot[$], q_second[$];
    logic [SB-1:0] q_size[$], q_pos[$];
    logic [8:0]    sb_q[$];
    logic [7:0]    win_px[16];

    int  checks = 0, failures = 0;
    int  cyc = 0, wr_count = 0, last_px_edge = 0, px_rd_cycles = 0, tok_rd_in_fill = 0;
    bit  pop_px, pop_pivot, pop_size, pop_pos, pop_second;
    bit  gap_en = 0, full_req = 0, chk_lat = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input int n, input int pv, input int m, input int sec);
        int l = 0, e = 0, mx = 0, mn = 255, sel;
        bit ex;
        for (int i = 0; i < n; i++) begin
            if (win_px[i] < pv) begin l++; if (win_px[i] > mx) mx = win_px[i]; end
            else if (win_px[i] == pv) e++;
            else if (win_px[i] < mn) mn = win_px[i];
        end
        if (n == 0 || m >= n)        begin sel = pv; ex = 0; end
        else if (l <= m && m < l + e) begin sel = pv; ex = 1; end
        else if (m == l - 1)         begin sel = mx; ex = 1; end
        else if (m == l + e)         begin sel = mn; ex = 1; end
        else if (m < l)              begin sel = mx; ex = 0; end
        else                         begin sel = mn; ex = 0; end
`ifdef MEDIAN_FINAL_AVG_EN
        sel = (sel + sec) / 2;
`else
        if (sec < 0) sel = 0;
`endif
        return {ex, 8'(sel)};
    endfunction

    // Consumption is decided at the rising edge from pre-edge handshake values.
    initial forever begin
        @(posedge clock);
        pop_px     = in_px_rd & ~in_px_empty;
        pop_pivot  = in_pivot_rd & ~in_pivot_empty;
        pop_size   = in_buff_size_rd & ~in_buff_size_empty;
        pop_pos    = in_median_pos_rd & ~in_median_pos_empty;
        pop_second = in_second_median_value_rd & ~in_second_median_value_empty;
        if (pop_px) last_px_edge = cyc + 1;
        if (in_px_rd) px_rd_cycles++;
        if (in_px_rd && (in_pivot_rd || in_buff_size_rd || in_median_pos_rd || in_second_median_value_rd))
            tok_rd_in_fill++;
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (pop_px && q_px.size() > 0)         void'(q_px.pop_front());
        if (pop_pivot && q_pivot.size() > 0)   void'(q_pivot.pop_front());
        if (pop_size && q_size.size() > 0)     void'(q_size.pop_front());
        if (pop_pos && q_pos.size() > 0)       void'(q_pos.pop_front());
        if (pop_second && q_second.size() > 0) void'(q_second.pop_front());
        in_px              = (q_px.size() > 0) ? q_px[0] : 8'd0;
        in_px_empty        = (q_px.size() == 0) || (gap_en && $urandom_range(0, 2) == 0);
        in_pivot           = (q_pivot.size() > 0) ? q_pivot[0] : 8'd0;
        in_pivot_empty     = (q_pivot.size() == 0);
        in_buff_size       = (q_size.size() > 0) ? q_size[0] : '0;
        in_buff_size_empty = (q_size.size() == 0);
        in_median_pos      = (q_pos.size() > 0) ? q_pos[0] : '0;
        in_median_pos_empty = (q_pos.size() == 0);
        in_second_median_value       = (q_second.size() > 0) ? q_second[0] : 8'd0;
        in_second_median_value_empty = (q_second.size() == 0);
        out_median_full    = full_req;
    end

    // Output monitor: a write happens at the next rising edge whenever wr is high mid-cycle.
    initial forever begin
        logic [8:0] exp;
        @(negedge clock);
        #2;
        if (reset && out_median_wr) begin
            wr_count++;
            $display("wr %0d: median=%0d exact=%0d edge=%0d", wr_count, out_median, out_exact, cyc + 1);
            if (sb_q.size() == 0) begin
                check("spurious_wr", 1, 0);
            end else begin
                exp = sb_q.pop_front();
                check("median", out_median, exp[7:0]);
                check("exact", out_exact, exp[8]);
                if (chk_lat) check("latency", cyc + 1, last_px_edge + 2);
            end
        end
    end

    task automatic send_window(input int n, input int pv, input int m, input int sec,
                               input bit stagger, input bit lat);
        int target;
        sb_q.push_back(model(n, pv, m, sec));
        chk_lat = lat;
        target  = wr_count + 1;
        for (int i = 0; i < n; i++) q_px.push_back(win_px[i]);
        q_pivot.push_back(8'(pv));
        if (stagger) repeat (2) @(negedge clock);
        q_size.push_back(SB'(n));
        if (stagger) @(negedge clock);
        q_pos.push_back(SB'(m));
        if (stagger) repeat (3) @(negedge clock);
        q_second.push_back(8'(sec));
        for (int i = 0; i < 300 && wr_count < target; i++) @(negedge clock);
        check("window_done", wr_count, target);
        repeat (2) @(negedge clock);
    endtask

    task automatic ramp();
        for (int i = 0; i < 16; i++) win_px[i] = 8'(i);
    endtask

    initial begin
        int base, snap;
        #1000000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, snap;
        repeat (3) @(negedge clock);
        #1;
        check("rst_median", out_median, 0);
        check("rst_exact", out_exact, 0);
        check("rst_wr", out_median_wr, 0);
        check("rst_rd", {in_px_rd, in_pivot_rd, in_buff_size_rd, in_median_pos_rd,
                         in_second_median_value_rd}, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        ramp();
        send_window(16, 8, 8, 9, 0, 1);   // pivot is the median
        send_window(16, 12, 8, 9, 0, 1);  // rank below pivot, max_lt, inexact
        send_window(16, 8, 9, 8, 1, 1);   // rank just above the pivot run
        snap = px_rd_cycles;
        send_window(0, 50, 8, 3, 0, 0);   // empty window
        check("size0_no_px_rd", px_rd_cycles - snap, 0);
        send_window(16, 8, 16, 4, 0, 1);  // position beyond the window

        // Output backpressure: data held, exactly one write after release.
        full_req = 1;
        base = wr_count;
        sb_q.push_back(model(16, 5, 8, 2));
        for (int i = 0; i < 16; i++) q_px.push_back(win_px[i]);
        q_pivot.push_back(8'd5); q_size.push_back(SB'(16));
        q_pos.push_back(SB'(8)); q_second.push_back(8'd2);
        chk_lat = 0;
        repeat (24) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            check("full_wr_low", out_median_wr, 0);
            check("full_hold_data", out_median, sb_q[0][7:0]);
        end
        check("full_no_write", wr_count, base);
        full_req = 0;
        repeat (8) @(negedge clock);
        check("full_one_write", wr_count, base + 1);

        gap_en = 1;
        send_window(16, 8, 8, 9, 0, 1);
        send_window(16, 3, 1, 9, 1, 1);
        gap_en = 0;

        for (int k = 0; k < 6; k++) begin
            int n, pv;
            n = $urandom_range(1, 16);
            for (int i = 0; i < 16; i++) win_px[i] = 8'($urandom_range(0, 40));
            pv = (k % 2 == 0) ? int'(win_px[$urandom_range(0, n - 1)]) : $urandom_range(0, 40);
            send_window(n, pv, $urandom_range(0, 17), $urandom_range(0, 255), k[0], 1);
        end

        // Reset in the middle of a partially filled window.
        ramp();
        for (int i = 0; i < 6; i++) q_px.push_back(win_px[i]);
        q_pivot.push_back(8'd8); q_size.push_back(SB'(16));
        q_pos.push_back(SB'(8)); q_second.push_back(8'd0);
        repeat (12) @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_rst_median", out_median, 0);
        check("mid_rst_exact", out_exact, 0);
        check("mid_rst_px_rd", in_px_rd, 0);
        check("mid_rst_tok_rd", {in_pivot_rd, in_buff_size_rd, in_median_pos_rd,
                                 in_second_median_value_rd}, 0);
        @(negedge clock);
        q_px.delete(); q_pivot.delete(); q_size.delete(); q_pos.delete(); q_second.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send_window(16, 12, 8, 9, 1, 1);

        check("tok_rd_in_fill", tok_rd_in_fill, 0);
        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
